// File: rtl/switch_alloc_rr.sv
// Round-robin switch allocator with per-output wormhole lock; grants are combinational, lock/pointer state registered.
// Optional build macro SA_NO_UTURN_EN: when defined, a request targeting its own input index is ignored.
module switch_alloc_rr #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_port,
  input  logic [NUM_PORTS-1:0]          req_tail,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*PORT_W-1:0]   out_sel,
  output logic [NUM_PORTS-1:0]          out_locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_t;

  lock_t             lock_q   [NUM_PORTS];
  logic [PORT_W-1:0] owner_q  [NUM_PORTS];
  logic [PORT_W-1:0] rr_ptr_q [NUM_PORTS];

  logic [PORT_W-1:0]    tgt      [NUM_PORTS];
  logic [PORT_W-1:0]    win      [NUM_PORTS];
  logic [PORT_W-1:0]    cand;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] out_gnt;

  function automatic logic [PORT_W-1:0] ptr_after(input logic [PORT_W-1:0] idx);
    return (32'(idx) == NUM_PORTS - 1) ? '0 : idx + PORT_W'(1);
  endfunction

  // Decode each input's target and drop requests that can never be served.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      tgt[i]      = req_port[i*PORT_W +: PORT_W];
`ifdef SA_NO_UTURN_EN
      eligible[i] = req_valid[i] && (32'(tgt[i]) < NUM_PORTS) && (tgt[i] != PORT_W'(i));
`else
      eligible[i] = req_valid[i] && (32'(tgt[i]) < NUM_PORTS);
`endif
    end
  end

  // Per-output arbitration: locked outputs serve only their owner, idle ones search from rr_ptr.
  always_comb begin
    hit       = '0;
    out_gnt   = '0;
    cand      = '0;
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      win[o] = '0;
      if (lock_q[o] == LOCKED) begin
        win[o] = owner_q[o];
        hit[o] = eligible[owner_q[o]] && (tgt[owner_q[o]] == PORT_W'(o));
      end else begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          cand = PORT_W'((32'(rr_ptr_q[o]) + k) % NUM_PORTS);
          if (!hit[o] && eligible[cand] && (tgt[cand] == PORT_W'(o))) begin
            hit[o] = 1'b1;
            win[o] = cand;
          end
        end
      end
      out_gnt[o] = hit[o] && out_ready[o] && !reset;
      if (out_gnt[o]) begin
        grant[win[o]]               = 1'b1;
        out_valid[o]                = 1'b1;
        out_sel[o*PORT_W +: PORT_W] = win[o];
      end
    end
  end

  // Lock and pointer update on each transferred flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        lock_q[o]   <= IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (out_gnt[o]) begin
          if (req_tail[win[o]]) begin
            lock_q[o]   <= IDLE;
            rr_ptr_q[o] <= ptr_after(win[o]);
          end else if (lock_q[o] == IDLE) begin
            lock_q[o]  <= LOCKED;
            owner_q[o] <= win[o];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      out_locked[o] = (lock_q[o] == LOCKED);
    end
  end

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Scoreboard bench for switch_alloc_rr: per-cycle expectations queued at stimulus time, popped at the falling edge.
module tb_switch_alloc_rr;

  localparam int unsigned N = 5;
  localparam int unsigned W = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_port;
  logic [N-1:0]   req_tail;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   grant;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_sel;
  logic [N-1:0]   out_locked;

  typedef struct {
    logic [N-1:0]   g;
    logic [N-1:0]   v;
    logic [N*W-1:0] s;
    logic [N-1:0]   l;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  switch_alloc_rr #(.NUM_PORTS(N), .PORT_W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_port(req_port),
    .req_tail(req_tail), .out_ready(out_ready), .grant(grant),
    .out_valid(out_valid), .out_sel(out_sel), .out_locked(out_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic [2:0] p0, p1, p2, p3, p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [14:0] sl(input int o, input logic [2:0] idx);
    logic [14:0] r;
    r = '0;
    r[o*3 +: 3] = idx;
    return r;
  endfunction

  task automatic stim(input logic rst, input logic [4:0] v, input logic [14:0] p,
                      input logic [4:0] t, input logic [4:0] r, input logic [4:0] eg,
                      input logic [4:0] ev, input logic [14:0] es, input logic [4:0] el);
    reset     = rst;
    req_valid = v;
    req_port  = p;
    req_tail  = t;
    out_ready = r;
    sbq.push_back('{g: eg, v: ev, s: es, l: el});
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      stim(1'b1, 5'b11111, pk(1, 0, 3, 2, 0), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL reset c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 5; c++) begin
      if (c < 3)
        stim(1'b0, 5'b00111, pk(3, 3, 3, 7, 7), 5'b11111, 5'b11111,
             5'(1 << c), 5'b01000, sl(3, 3'(c)), 5'b0);
      else if (c == 3)
        stim(1'b0, 5'b10001, pk(3, 7, 7, 7, 3), 5'b11111, 5'b11111,
             5'b10000, 5'b01000, sl(3, 4), 5'b0);
      else
        stim(1'b0, 5'b10001, pk(3, 7, 7, 7, 3), 5'b11111, 5'b11111,
             5'b00001, 5'b01000, sl(3, 0), 5'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL contention c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wormhole();
    for (int c = 0; c < 5; c++) begin
      if (c < 4)
        stim(1'b0, 5'b00110, pk(7, 0, 0, 7, 7), (c == 3) ? 5'b00110 : 5'b00100, 5'b11111,
             5'b00010, 5'b00001, sl(0, 1), (c == 0) ? 5'b00000 : 5'b00001);
      else
        stim(1'b0, 5'b00100, pk(7, 7, 0, 7, 7), 5'b00100, 5'b11111,
             5'b00100, 5'b00001, sl(0, 2), 5'b00000);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL wormhole c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: stim(1'b0, 5'b11000, pk(7, 7, 7, 0, 0), 5'b10000, 5'b11111, 5'b01000, 5'b00001, sl(0, 3), 5'b00000);
        1, 2: stim(1'b0, 5'b11000, pk(7, 7, 7, 0, 0), 5'b10000, 5'b11110, 5'b0, 5'b0, 15'b0, 5'b00001);
        3: stim(1'b0, 5'b10000, pk(7, 7, 7, 0, 0), 5'b10000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b00001);
        4: stim(1'b0, 5'b11000, pk(7, 7, 7, 0, 0), 5'b10000, 5'b11111, 5'b01000, 5'b00001, sl(0, 3), 5'b00001);
        5: stim(1'b0, 5'b11000, pk(7, 7, 7, 0, 0), 5'b11000, 5'b11111, 5'b01000, 5'b00001, sl(0, 3), 5'b00001);
        default: stim(1'b0, 5'b10000, pk(7, 7, 7, 0, 0), 5'b10000, 5'b11111, 5'b10000, 5'b00001, sl(0, 4), 5'b00000);
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL backpressure c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_parallel();
    for (int c = 0; c < 2; c++) begin
      if (c == 0)
        stim(1'b0, 5'b10011, pk(1, 0, 7, 7, 2), 5'b11111, 5'b11111,
             5'b10011, 5'b00111, sl(1, 0) | sl(0, 1) | sl(2, 4), 5'b0);
      else
        stim(1'b0, 5'b10011, pk(1, 0, 7, 7, 2), 5'b11111, 5'b11011,
             5'b00011, 5'b00011, sl(1, 0) | sl(0, 1), 5'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL parallel c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_invalid_reset();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: stim(1'b0, 5'b01000, pk(7, 7, 7, 7, 7), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
        1: stim(1'b0, 5'b01001, pk(7, 7, 7, 7, 7), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
        2: stim(1'b0, 5'b00100, pk(7, 7, 1, 7, 7), 5'b00000, 5'b11111, 5'b00100, 5'b00010, sl(1, 2), 5'b00000);
        3: stim(1'b0, 5'b00100, pk(7, 7, 1, 7, 7), 5'b00000, 5'b11111, 5'b00100, 5'b00010, sl(1, 2), 5'b00010);
        4: stim(1'b1, 5'b10100, pk(7, 7, 1, 7, 1), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b00010);
        5: stim(1'b0, 5'b10000, pk(7, 7, 7, 7, 1), 5'b00000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 5'b00000);
        6: stim(1'b0, 5'b10000, pk(7, 7, 7, 7, 1), 5'b10000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 5'b00010);
        default: stim(1'b0, 5'b00000, pk(7, 7, 7, 7, 7), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b00000);
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL invalid_reset c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_uturn();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
`ifdef SA_NO_UTURN_EN
        stim(1'b0, 5'b00100, pk(7, 7, 2, 7, 7), 5'b11111, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
`else
        stim(1'b0, 5'b00100, pk(7, 7, 2, 7, 7), 5'b11111, 5'b11111, 5'b00100, 5'b00100, sl(2, 2), 5'b0);
`endif
      end else begin
        stim(1'b0, 5'b00000, pk(7, 7, 7, 7, 7), 5'b00000, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
      end
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s || out_locked !== e.l) begin
        failures++;
        $display("FAIL uturn c%0d: grant=%b out_valid=%b out_sel=%h out_locked=%b required %b %b %h %b",
                 c, grant, out_valid, out_sel, out_locked, e.g, e.v, e.s, e.l);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_port  = '1;
    req_tail  = '0;
    out_ready = '0;
    @(posedge clk); #1;
    test_reset();
    test_contention();
    test_wormhole();
    test_backpressure();
    test_parallel();
    test_invalid_reset();
    test_uturn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
